// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port SRAM arbiter: FSM states, owner
// encoding and the default SRAM wait-state count.
package mem_port_arbiter_pkg;

  localparam int unsigned WaitCyclesDefault = 2;
  localparam int unsigned CntW              = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerIf  = 1'b0,
    OwnerMem = 1'b1
  } owner_e;

endpackage

// File: rtl/wait_counter.sv
// 4-bit down counter that paces SRAM wait states; saturates at zero.
module wait_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-stage accesses onto one single-port
// SRAM with alternating priority under contention and fetch cancellation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  input  logic        ifCancel,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWdata,
  output logic        ifValid,
  output logic [31:0] ifRdata,
  output logic        ifFreeze,
  output logic        memValid,
  output logic [31:0] memRdata,
  output logic        memFreeze,
  output logic [31:0] sramAddr,
  output logic [31:0] sramWdata,
  output logic        sramWe,
  output logic        sramRe,
  input  logic [31:0] sramRdata
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_owner_q, last_owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        mem_valid_q, mem_valid_d;

  logic cnt_load, cnt_dec, cnt_zero;
  logic mem_pend, if_pend, grant_mem;

  wait_counter u_wait_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (CntW'(WAIT_CYCLES)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign mem_pend = memRead | memWrite;
  assign if_pend  = ifReq & ~ifCancel;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_valid_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    grant_mem    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_pend || if_pend) begin
          // MEM wins a tie unless it owned the previous access.
          grant_mem = mem_pend && (!if_pend || (last_owner_q != OwnerMem));
          state_d   = StAccess;
          cnt_load  = 1'b1;
          if (grant_mem) begin
            owner_d = OwnerMem;
            addr_d  = memAddr;
            wdata_d = memWdata;
            we_d    = memWrite;
          end else begin
            owner_d = OwnerIf;
            addr_d  = ifAddr;
            we_d    = 1'b0;
          end
        end
      end
      StAccess: begin
        if ((owner_q == OwnerIf) && ifCancel) begin
          state_d = StIdle;
        end else if (cnt_zero) begin
          state_d      = StDone;
          last_owner_d = owner_q;
          if (owner_q == OwnerIf) begin
            if_rdata_d = sramRdata;
            if_valid_d = 1'b1;
          end else begin
            if (!we_q) begin
              mem_rdata_d = sramRdata;
            end
            mem_valid_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnerIf;
      last_owner_q <= OwnerIf;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_valid_q  <= mem_valid_d;
    end
  end

  // Strobes decode from state so a reset drops them without waiting for a clock.
  assign sramWe    = (state_q == StAccess) & we_q;
  assign sramRe    = (state_q == StAccess) & ~we_q;
  assign sramAddr  = addr_q;
  assign sramWdata = wdata_q;

  assign ifValid   = if_valid_q;
  assign memValid  = mem_valid_q;
  assign ifRdata   = if_rdata_q;
  assign memRdata  = mem_rdata_q;
  assign ifFreeze  = ifReq & ~if_valid_q;
  assign memFreeze = mem_pend & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at WAIT_CYCLES=2; inputs change and
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifReq, ifCancel, memRead, memWrite;
  logic [31:0] ifAddr, memAddr, memWdata, sramRdata;
  logic        ifValid, ifFreeze, memValid, memFreeze, sramWe, sramRe;
  logic [31:0] ifRdata, memRdata, sramAddr, sramWdata;

  int unsigned n_vec;
  int unsigned n_err;

  logic [31:0] order [4];
  int unsigned n_acc;
  logic        acc, prev;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifReq     (ifReq),
    .ifAddr    (ifAddr),
    .ifCancel  (ifCancel),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .memAddr   (memAddr),
    .memWdata  (memWdata),
    .ifValid   (ifValid),
    .ifRdata   (ifRdata),
    .ifFreeze  (ifFreeze),
    .memValid  (memValid),
    .memRdata  (memRdata),
    .memFreeze (memFreeze),
    .sramAddr  (sramAddr),
    .sramWdata (sramWdata),
    .sramWe    (sramWe),
    .sramRe    (sramRe),
    .sramRdata (sramRdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    ifReq = 0; ifCancel = 0; memRead = 0; memWrite = 0;
    ifAddr = '0; memAddr = '0; memWdata = '0; sramRdata = '0;
    order[0] = '0; order[1] = '0; order[2] = '0; order[3] = '0;

    // Reset values
    #1 rst = 1'b1;
    tick();
    check("rst_sramRe", 32'(sramRe), 32'd0);
    check("rst_sramWe", 32'(sramWe), 32'd0);
    check("rst_sramAddr", sramAddr, 32'h0);
    check("rst_sramWdata", sramWdata, 32'h0);
    check("rst_ifValid", 32'(ifValid), 32'd0);
    check("rst_memValid", 32'(memValid), 32'd0);
    check("rst_ifRdata", ifRdata, 32'h0);
    check("rst_memRdata", memRdata, 32'h0);
    rst = 1'b0;
    tick();

    // Single IF read
    ifReq = 1; ifAddr = 32'h40; sramRdata = 32'hE3A01005;
    #1 check("if_freeze_pre", 32'(ifFreeze), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("if_sramRe", 32'(sramRe), 32'd1);
      check("if_sramAddr", sramAddr, 32'h40);
      check("if_valid_early", 32'(ifValid), 32'd0);
      check("if_freeze_wait", 32'(ifFreeze), 32'd1);
    end
    tick();
    check("if_done_sramRe", 32'(sramRe), 32'd0);
    check("if_valid", 32'(ifValid), 32'd1);
    check("if_rdata", ifRdata, 32'hE3A01005);
    check("if_freeze_done", 32'(ifFreeze), 32'd0);
    ifReq = 0;
    tick();
    check("if_valid_pulse", 32'(ifValid), 32'd0);
    check("if_rdata_hold", ifRdata, 32'hE3A01005);

    // Simultaneous requests, lastOwner=IF: MEM first, then IF
    ifReq = 1; ifAddr = 32'h44; memRead = 1; memAddr = 32'h200; sramRdata = 32'h11111111;
    tick();
    check("both_mem_addr", sramAddr, 32'h200);
    check("both_mem_re", 32'(sramRe), 32'd1);
    tick(); tick(); tick();
    check("both_mem_valid", 32'(memValid), 32'd1);
    check("both_mem_rdata", memRdata, 32'h11111111);
    check("both_if_waiting", 32'(ifValid), 32'd0);
    check("both_if_freeze", 32'(ifFreeze), 32'd1);
    check("both_mem_freeze", 32'(memFreeze), 32'd0);
    memRead = 0; sramRdata = 32'h22222222;
    tick();
    check("both_idle", 32'(sramRe), 32'd0);
    tick();
    check("both_if_addr", sramAddr, 32'h44);
    check("both_if_re", 32'(sramRe), 32'd1);
    tick(); tick(); tick();
    check("both_if_valid", 32'(ifValid), 32'd1);
    check("both_if_rdata", ifRdata, 32'h22222222);
    check("both_mem_rdata_hold", memRdata, 32'h11111111);
    ifReq = 0;
    tick();

    // Fairness: both held, expect MEM, IF, MEM
    memRead = 1; memAddr = 32'h300; ifReq = 1; ifAddr = 32'h48; sramRdata = 32'h33333333;
    n_acc = 0; prev = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      acc = sramRe | sramWe;
      if (acc && !prev) begin
        if (n_acc < 4) order[n_acc] = sramAddr;
        n_acc++;
      end
      prev = acc;
    end
    check("fair_last_valid", 32'(memValid), 32'd1);
    check("fair_count", n_acc, 32'd3);
    check("fair_first_mem", order[0], 32'h300);
    check("fair_then_if", order[1], 32'h48);
    check("fair_then_mem", order[2], 32'h300);
    memRead = 0; ifReq = 0;
    tick();

    // Cancel in the 2nd ACCESS cycle of an IF read
    ifReq = 1; ifAddr = 32'h80; sramRdata = 32'h44444444;
    tick();
    check("cancel_addr", sramAddr, 32'h80);
    check("cancel_re", 32'(sramRe), 32'd1);
    tick();
    ifCancel = 1; ifReq = 0;
    tick();
    check("cancel_idle", 32'(sramRe), 32'd0);
    check("cancel_no_valid", 32'(ifValid), 32'd0);
    check("cancel_rdata", ifRdata, 32'h33333333);
    ifCancel = 0;
    tick();
    check("cancel_no_valid2", 32'(ifValid), 32'd0);
    check("cancel_rdata2", ifRdata, 32'h33333333);

    // Write (read+write both high), ifCancel ignored
    memWrite = 1; memRead = 1; memAddr = 32'h100; memWdata = 32'hDEADBEEF;
    sramRdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_we", 32'(sramWe), 32'd1);
      check("wr_re", 32'(sramRe), 32'd0);
      check("wr_addr", sramAddr, 32'h100);
      check("wr_data", sramWdata, 32'hDEADBEEF);
      check("wr_valid_early", 32'(memValid), 32'd0);
      ifCancel = 1;
    end
    tick();
    check("wr_valid", 32'(memValid), 32'd1);
    check("wr_we_off", 32'(sramWe), 32'd0);
    check("wr_rdata_hold", memRdata, 32'h33333333);
    memWrite = 0; memRead = 0; ifCancel = 0;
    tick();
    check("wr_valid_pulse", 32'(memValid), 32'd0);

    // Reset during the 2nd ACCESS cycle of a write
    memWrite = 1; memAddr = 32'h104; memWdata = 32'hCAFEF00D;
    tick();
    check("rstw_we", 32'(sramWe), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("rstw_we_async", 32'(sramWe), 32'd0);
    check("rstw_re", 32'(sramRe), 32'd0);
    check("rstw_addr", sramAddr, 32'h0);
    check("rstw_wdata", sramWdata, 32'h0);
    check("rstw_ifRdata", ifRdata, 32'h0);
    check("rstw_memRdata", memRdata, 32'h0);
    check("rstw_memValid", 32'(memValid), 32'd0);
    memWrite = 0;
    tick();
    ifReq = 1; ifAddr = 32'h8C; sramRdata = 32'h66666666; rst = 1'b0;
    #1 check("rel_no_grant", 32'(sramRe), 32'd0);
    tick();
    check("rel_grant_re", 32'(sramRe), 32'd1);
    check("rel_grant_addr", sramAddr, 32'h8C);
    tick(); tick(); tick();
    check("rel_if_valid", 32'(ifValid), 32'd1);
    check("rel_if_rdata", ifRdata, 32'h66666666);
    ifReq = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the number of extra cycles the single-port SRAM needs per access (legal range 0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ifReq input 1 and ifAddr input 32, the instruction-fetch read request and word address.
REQ-005 SHALL have port ifCancel input 1, asserted on a taken branch to abandon the in-flight fetch.
REQ-006 SHALL have ports memRead input 1, memWrite input 1, memAddr input 32 and memWdata input 32, the data-stage request.
REQ-007 SHALL have ports ifValid output 1, ifRdata output 32, ifFreeze output 1, memValid output 1, memRdata output 32 and memFreeze output 1.
REQ-008 SHALL have ports sramAddr output 32, sramWdata output 32, sramWe output 1, sramRe output 1 and sramRdata input 32.

Function
REQ-009 SHALL implement the states IDLE, ACCESS and DONE, plus a 1-bit owner register (IF or MEM) and a 1-bit lastOwner register.
REQ-010 In IDLE, a data request (memRead or memWrite) is pending and an IF request (ifReq and not ifCancel) is pending.
REQ-011 In IDLE with no pending request, the block SHALL stay in IDLE.
REQ-012 In IDLE with only one pending request, the block SHALL grant that requester.
REQ-013 In IDLE with both requests pending, MEM SHALL win unless lastOwner is MEM, in which case IF SHALL win.
REQ-014 On a grant, the block SHALL go to ACCESS, latch the address (and memWdata and the write flag for MEM), and load the wait counter with WAIT_CYCLES.
REQ-015 In ACCESS, sramAddr, sramWdata, sramWe and sramRe SHALL be driven from the latched values and held constant for exactly WAIT_CYCLES+1 cycles.
REQ-016 In ACCESS, the counter SHALL decrement each cycle.
REQ-017 When the counter is 0 in ACCESS, the block SHALL register sramRdata into the owner's rdata register, go to DONE and set lastOwner to the owner.
REQ-018 In DONE, the owner's valid output SHALL be high for exactly one cycle, new requests SHALL NOT be granted, and the next state SHALL be IDLE.
REQ-019 ifRdata and memRdata SHALL hold their last captured values until the next completion for the same owner.
REQ-020 ifFreeze SHALL be ifReq AND NOT ifValid (combinational).
REQ-021 memFreeze SHALL be (memRead OR memWrite) AND NOT memValid (combinational).
REQ-022 If ifCancel is high during an IF-owned read in ACCESS, the block SHALL return to IDLE on the next edge without asserting ifValid and without updating ifRdata.
REQ-023 ifCancel SHALL have no effect on a MEM-owned access.
REQ-024 A write SHALL never be aborted; memRdata SHALL be unchanged on write completion, but memValid SHALL still pulse.
REQ-025 With WAIT_CYCLES=0, ACCESS SHALL last exactly 1 cycle; the total grant-to-valid latency SHALL be WAIT_CYCLES+2 cycles.
REQ-026 If memRead and memWrite are both high, the request SHALL be treated as a write.

Reset
REQ-027 On rst high, the block SHALL immediately set the state to IDLE, the counter to 0, lastOwner to IF, ifValid/memValid/sramWe/sramRe to 0, and sramAddr/sramWdata/ifRdata/memRdata to 0.
REQ-028 Reset asserted during ACCESS SHALL abandon the access, including a write in progress; sramWe SHALL drop asynchronously.
REQ-029 After rst is released, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-030 The state enumeration, the owner encoding and the WAIT_CYCLES default SHALL live in the shared processor definitions package.
REQ-031 The wait counter (load, decrement, zero flag, 4 bits) SHALL be a sub-module named wait_counter.
REQ-032 The remaining logic (FSM, arbitration, latches, freeze logic) SHALL stay in mem_port_arbiter.

Verification (WAIT_CYCLES=2)
REQ-033 Single IF read: ifReq=1, ifAddr=0x40, sramRdata=0xE3A01005 -> sramRe high for 3 cycles; ifValid pulses 4 cycles after the grant edge with ifRdata=0xE3A01005; ifFreeze is high until then.
REQ-034 Simultaneous requests with lastOwner=IF: ifReq and memRead both high -> MEM is served first; IF is granted in the IDLE following DONE.
REQ-035 Fairness: MEM requests back-to-back with ifReq held -> accesses alternate MEM, IF, MEM; neither requester waits more than 2 accesses.
REQ-036 Cancel: an IF read at 0x80 with ifCancel pulsed in the 2nd ACCESS cycle -> return to IDLE next edge, no ifValid, ifRdata unchanged.
REQ-037 Write: memWrite=1, memAddr=0x100, memWdata=0xDEADBEEF -> sramWe high for exactly 3 cycles with stable address and data; memValid pulses; ifCancel in the same window is ignored.
REQ-038 Reset mid-access: rst asserted in the 2nd ACCESS cycle of a write -> sramWe=0 and state IDLE before the next edge; all outputs are at their reset values.
